// File: rtl/arb2_mux_ctrl.sv
// Round-robin two-requester packet arbiter driving a WIDTH-bit 2:1 mux.
// A grant holds until the owner's last beat or MAX_BEATS beats.
module arb2_mux_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 8,
    parameter int CW        = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             v0,
    input  logic [WIDTH-1:0] d0,
    input  logic             last0,
    output logic             r0,
    input  logic             v1,
    input  logic [WIDTH-1:0] d1,
    input  logic             last1,
    output logic             r1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel,
    output logic [1:0]       grant,
    output logic             preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [1:0]    grant_q, grant_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          preempt_q, preempt_d;

    logic             busy;
    logic             v_sel;
    logic             last_sel;
    logic [WIDTH-1:0] d_sel;
    logic             xfer;
    logic             owner;

    always_comb begin
        busy     = (state_q == BUSY);
        v_sel    = sel_q ? v1 : v0;
        last_sel = sel_q ? last1 : last0;
        d_sel    = sel_q ? d1 : d0;
        y        = busy ? d_sel : '0;
        y_valid  = busy & v_sel;
        y_last   = busy & (last_sel | (cnt_q == LAST_CNT));
        r0       = busy & ~sel_q & y_ready;
        r1       = busy & sel_q & y_ready;
        xfer     = y_valid & y_ready;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        owner     = (v0 & v1) ? prio_q : v1;
        if (!busy) begin
            if (v0 | v1) begin
                state_d = BUSY;
                sel_d   = owner;
                grant_d = owner ? 2'b10 : 2'b01;
                cnt_d   = '0;
            end
        end else if (xfer) begin
            if (y_last) begin
                // sel is left alone; y is gated off while idle anyway
                state_d   = IDLE;
                grant_d   = 2'b00;
                cnt_d     = '0;
                prio_d    = ~sel_q;
                preempt_d = ~last_sel;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            grant_q   <= 2'b00;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign preempt = preempt_q;

endmodule

// File: doc/arb2_mux_ctrl.md
Name: arb2_mux_ctrl

Overview:
Round-robin controller that shares one downstream consumer between two packet-producing requesters.
It drives the select of a WIDTH-bit 2:1 data multiplexer and owns the valid/ready handshake on both sides.
A grant is held for a whole packet (until the `last` beat) or for MAX_BEATS beats, whichever comes first.
It sits between two producer pipelines and a single shared bus/functional unit.

Parameters:
WIDTH, 32, data width of each requester and the output.
MAX_BEATS, 8, maximum beats per grant before forced release (>=1).
CW, 3, beat counter width; must satisfy 2**CW >= MAX_BEATS.

Ports:
clk  in  1  clock, rising edge.
clrn  in  1  asynchronous active-low reset (clear).
v0  in  1  requester 0 valid.
d0  in  WIDTH  requester 0 data.
last0  in  1  requester 0 final beat of packet.
r0  out  1  requester 0 ready.
v1  in  1  requester 1 valid.
d1  in  WIDTH  requester 1 data.
last1  in  1  requester 1 final beat of packet.
r1  out  1  requester 1 ready.
y  out  WIDTH  muxed data to consumer.
y_valid  out  1  output valid.
y_last  out  1  output last (owner's last, or forced on preemption beat).
y_ready  in  1  consumer ready.
sel  out  1  current mux select (owner index).
grant  out  2  one-hot grant {g1,g0}.
preempt  out  1  one-cycle pulse when a grant ends by MAX_BEATS without `last`.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, grant=00, sel=0, prio=0, beat count=0, preempt=0.
  - y_valid, y_last, r0 and r1 all 0; y=0.
  - Reset mid-packet abandons the packet immediately; no recovery beat is emitted.
- States: IDLE, BUSY. sel, grant, prio, count and preempt are registered. y, y_valid, y_last, r0 and r1 are combinational from state/sel.
- IDLE:
  - Outputs y=0, y_valid=0, y_last=0, r0=r1=0.
  - At the clock edge, pick the owner:
    - only v0 -> owner 0;
    - only v1 -> owner 1;
    - both valid -> owner = prio.
  - Then state=BUSY, sel=owner, grant=onehot(owner), count=0.
  - Neither valid -> stay in IDLE.
  - Latency from valid to grant is 1 cycle; the first beat can transfer in the cycle after the grant.
- BUSY:
  - y=d_sel, y_valid=v_sel, r_sel=y_ready; the non-owner's ready is 0.
  - y_last = last_sel OR (count==MAX_BEATS-1).
  - A beat transfers when v_sel & y_ready; count increments on each transfer.
  - Owner deasserts valid mid-packet: grant is held, y_valid=0, and the non-owner keeps waiting (no timeout).
- Release, on a transferring beat where y_last=1:
  - state=IDLE, grant=00, count=0, prio=~sel.
  - preempt=1 for one cycle iff last_sel=0 on that beat.
  - sel keeps its old value; y is gated to 0 in IDLE.
  - There is always one IDLE bubble cycle between grants.
- Fairness: after any release, the other requester wins the next tie. A lone requester may be re-granted back-to-back, one bubble apart.
- MAX_BEATS=1: every beat is its own grant. y_last=1 on all beats, and preempt pulses on each beat with last=0.
- Counter never wraps: it is cleared on release and cannot exceed MAX_BEATS-1.
- Data and last from the non-owner are ignored and must not affect any output.

Test Plan:
1. Reset then idle: clrn=0 for 2 cycles with v0=v1=1 -> grant=00, y_valid=0, r0=r1=0; after release of clrn, grant=01 at first edge (prio=0).
2. Tie rotation: v0=v1=1 continuously, 2-beat packets (last on beat 2), y_ready=1 -> grant sequence 01,00,10,00,01,...; y alternates d0,d0,d1,d1; preempt stays 0.
3. Preemption: MAX_BEATS=8, v0=1 with last0=0 for 20 beats, v1=1 -> 8 beats from requester 0 with y_last on beat 8, preempt pulse, idle cycle, then grant=10.
4. Backpressure/stall: owner 0 with y_ready toggling 1,0,1 and v0 dropped for 3 cycles mid-packet -> count advances only on v0&y_ready; grant holds 01; r1=0 throughout even with v1=1.
5. Async reset mid-packet: clrn pulsed low between edges during beat 3 -> grant, y_valid, r0 go 0 immediately without a clock; after release, arbitration restarts with prio=0 and count=0.
6. Lone requester: only v1=1 with single-beat packets (last1=1) -> grant 10,00,10,00; prio toggles to 0 after each release; each beat accepted on the cycle after its grant.
